// File: rtl/shift_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// shift_cmd_ctrl
//
// Command sequencer for a free-running universal shift register. One command
// is taken per transaction: a parallel load (or clear) is issued, followed by
// `amt` single-bit shift cycles. The register output is then returned on a
// valid/ready result channel.
//
// Build option:
//   SHIFT_CMD_ROTATE_EN  defined   : ROL/ROR feed Q back into SL/SR.
//                        undefined : ROL runs as SLL, ROR runs as SRL.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op, cmd_amt,      operation, shift count, load word
//   cmd_data
//   S1, S0, SL, SR        register mode and serial fill bits
//   PData, shreg_clear    parallel load word, synchronous clear pulse
//   Q                     register output fed back
//   res_valid/res_ready   result handshake
//   res_data              final register contents (pass-through of Q)
//   busy                  high outside IDLE
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// LOAD   | one cycle of parallel load (or clear for CLR)
// SHIFT  | one single-bit shift per cycle, counter counts down to 1
// DONE   | register held, result offered until res_ready
// ---------------------------------------------------------------------------
module shift_cmd_ctrl #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             S1,
  output logic             S0,
  output logic             SL,
  output logic             SR,
  output logic [WIDTH-1:0] PData,
  output logic             shreg_clear,
  input  logic [WIDTH-1:0] Q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_SLL   = 3'b001;
  localparam logic [2:0] OP_SRL   = 3'b010;
  localparam logic [2:0] OP_SRA   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_SLL) && (op <= OP_ROR);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    S1          = 1'b0;
    S0          = 1'b0;
    SL          = 1'b0;
    SR          = 1'b0;
    shreg_clear = 1'b0;
    res_valid   = 1'b0;
    cmd_ready   = 1'b0;
    busy        = 1'b1;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          // Non-shift ops ignore the amount, so a zero count routes LOAD -> DONE.
          cnt_d   = is_shift_op(cmd_op) ? cmd_amt : '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (op_q == OP_CLR) begin
          shreg_clear = 1'b1;
        end else begin
          S1 = 1'b1;
          S0 = 1'b1;
        end
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end

      ST_SHIFT: begin
        cnt_d = cnt_q - AMT_W'(1);
        case (op_q)
          OP_SLL: S1 = 1'b1;
          OP_ROL: begin
            S1 = 1'b1;
`ifdef SHIFT_CMD_ROTATE_EN
            SL = Q[WIDTH-1];
`endif
          end
          OP_SRL: S0 = 1'b1;
          OP_SRA: begin
            S0 = 1'b1;
            SR = Q[WIDTH-1];
          end
          OP_ROR: begin
            S0 = 1'b1;
`ifdef SHIFT_CMD_ROTATE_EN
            SR = Q[0];
`endif
          end
          default: ;
        endcase
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign PData    = data_q;
  assign res_data = Q;

endmodule

// File: tb/tb_shift_cmd_ctrl.sv
module tb_shift_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_amt;
  logic [31:0] cmd_data;
  logic        S1, S0, SL, SR;
  logic [31:0] PData;
  logic        shreg_clear;
  logic [31:0] Q;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int edges, n_load, n_left, n_right, n_clr, sl_ones, sr_ones;

  shift_cmd_ctrl #(.WIDTH(32), .AMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .S1(S1), .S0(S0), .SL(SL), .SR(SR),
    .PData(PData), .shreg_clear(shreg_clear), .Q(Q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral universal shift register downstream of the controller.
  initial Q = 32'h0;
  always @(posedge clk) begin
    if (shreg_clear) Q <= 32'h0;
    else begin
      case ({S1, S0})
        2'b01: Q <= {SR, Q[31:1]};
        2'b10: Q <= {Q[30:0], SL};
        2'b11: Q <= PData;
        default: Q <= Q;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one command; the accepting edge is counted as edge 1. Returns once
  // res_valid is seen (or after a bounded number of edges) with per-mode counts.
  task automatic do_cmd(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] data);
    edges = 0; n_load = 0; n_left = 0; n_right = 0; n_clr = 0; sl_ones = 0; sr_ones = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data;
    tick;
    edges = 1;
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_amt = 5'd0; cmd_data = 32'h0;
    while (res_valid !== 1'b1 && edges < 100) begin
      if ({S1, S0} == 2'b11) n_load++;
      if ({S1, S0} == 2'b10) n_left++;
      if ({S1, S0} == 2'b01) n_right++;
      if (shreg_clear) n_clr++;
      if (SL) sl_ones++;
      if (SR) sr_ones++;
      tick;
      edges++;
    end
  endtask

  task automatic finish_cmd;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("ready_after_done", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b0; cmd_amt = 5'd0; cmd_data = 32'h0;
    res_ready = 1'b0;
    #12;
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_mode", {28'b0, S1, S0, SL, SR}, 32'd0);
    chk("rst_pdata", PData, 32'h0);
    chk("rst_clear", {31'b0, shreg_clear}, 32'd0);
    rst_n = 1'b1;
    tick;

    // LOAD ignores amt
    do_cmd(3'b000, 5'd7, 32'hDEADBEEF);
    chk("load_edges", edges, 32'd2);
    chk("load_cycles", n_load, 32'd1);
    chk("load_shifts", n_left + n_right, 32'd0);
    chk("load_res", res_data, 32'hDEADBEEF);
    chk("load_pdata", PData, 32'hDEADBEEF);
    chk("load_busy", {31'b0, busy}, 32'd1);
    finish_cmd;
    tick;

    // SLL 1 by 4
    do_cmd(3'b001, 5'd4, 32'h00000001);
    chk("sll_edges", edges, 32'd6);
    chk("sll_left", n_left, 32'd4);
    chk("sll_sl", sl_ones, 32'd0);
    chk("sll_res", res_data, 32'h00000010);
    finish_cmd;
    tick;

    // SRA sign fill
    do_cmd(3'b011, 5'd3, 32'h80000000);
    chk("sra_edges", edges, 32'd5);
    chk("sra_right", n_right, 32'd3);
    chk("sra_sr", sr_ones, 32'd3);
    chk("sra_res", res_data, 32'hF0000000);
    finish_cmd;
    tick;

    // SRL zero fill
    do_cmd(3'b010, 5'd3, 32'h80000000);
    chk("srl_sr", sr_ones, 32'd0);
    chk("srl_res", res_data, 32'h10000000);
    finish_cmd;
    tick;

    // ROR / ROL
    do_cmd(3'b101, 5'd1, 32'h00000001);
`ifdef SHIFT_CMD_ROTATE_EN
    chk("ror_res", res_data, 32'h80000000);
`else
    chk("ror_res", res_data, 32'h00000000);
`endif
    finish_cmd;
    tick;
    do_cmd(3'b100, 5'd2, 32'h80000001);
`ifdef SHIFT_CMD_ROTATE_EN
    chk("rol_res", res_data, 32'h00000006);
`else
    chk("rol_res", res_data, 32'h00000004);
`endif
    finish_cmd;
    tick;

    // amt = 0 behaves as a load
    do_cmd(3'b001, 5'd0, 32'h00000005);
    chk("amt0_edges", edges, 32'd2);
    chk("amt0_left", n_left, 32'd0);
    chk("amt0_res", res_data, 32'h00000005);
    finish_cmd;
    tick;

    // amt = 31, no counter wrap
    do_cmd(3'b010, 5'd31, 32'hFFFFFFFF);
    chk("amt31_edges", edges, 32'd33);
    chk("amt31_right", n_right, 32'd31);
    chk("amt31_res", res_data, 32'h00000001);
    finish_cmd;
    tick;

    // Result held under back-pressure; new command ignored
    do_cmd(3'b001, 5'd2, 32'h00000003);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2); cmd_op = 3'b000; cmd_data = 32'h00001234;
      tick;
      chk("hold_res", res_data, 32'h0000000C);
      chk("hold_mode", {30'b0, S1, S0}, 32'd0);
      chk("hold_ready", {31'b0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0; cmd_data = 32'h0;
    finish_cmd;
    tick;
    chk("hold_not_taken", {31'b0, busy}, 32'd0);
    chk("hold_pdata", PData, 32'h00000003);

    // Asynchronous reset in the middle of a long shift
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_amt = 5'd20; cmd_data = 32'h00000001;
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    chk("mid_shift_mode", {30'b0, S1, S0}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", {28'b0, S1, S0, SL, SR}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("arst_pdata", PData, 32'h0);
    chk("arst_valid", {31'b0, res_valid}, 32'd0);
    #1 rst_n = 1'b1;
    tick;

    // CLR after reset
    do_cmd(3'b110, 5'd9, 32'h0000ABCD);
    chk("clr_edges", edges, 32'd2);
    chk("clr_pulses", n_clr, 32'd1);
    chk("clr_loads", n_load, 32'd0);
    chk("clr_res", res_data, 32'h0);
    finish_cmd;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
